uart_tx_sched: RTL and testbench

UART_TX_SCHED -- requirements
Module: uart_tx_sched

---
 rtl/uart_tx_sched.sv | 147 ++++++++++++++
 tb/tb_uart_tx_sched.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// Two-requester byte scheduler for a UART transmitter; grant->ACK 1 cycle, ACK->TX_DATA_VALID 1 cycle, then waits for TX_BUSY high/low per byte.
// Requests stall (unacknowledged) while not IDLE; ties go to requester 0, or round-robin when TX_SCHED_ROUND_ROBIN_EN is defined.
module uart_tx_sched #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    REQ0_VLD,
    input  logic [DATA_WIDTH-1:0]   REQ0_DATA,
    output logic                    REQ0_ACK,
    input  logic                    REQ1_VLD,
    input  logic [2*DATA_WIDTH-1:0] REQ1_DATA,
    output logic                    REQ1_ACK,
    input  logic                    TX_BUSY,
    output logic [DATA_WIDTH-1:0]   TX_P_DATA,
    output logic                    TX_DATA_VALID,
    output logic                    SCHED_BUSY
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } state_t;

    state_t                  state, state_nxt;
    logic [DATA_WIDTH-1:0]   cur_byte, cur_byte_nxt;
    logic [DATA_WIDTH-1:0]   msb_byte, msb_byte_nxt;
    logic                    msb_pend, msb_pend_nxt;
    logic [DATA_WIDTH-1:0]   tx_p_data_nxt;
    logic                    tx_data_valid_nxt;
    logic                    req0_ack_nxt, req1_ack_nxt;
    logic                    sched_busy_nxt;
    logic                    gnt0, gnt1;

`ifdef TX_SCHED_ROUND_ROBIN_EN
    // 1 = requester 1 received the most recent grant
    logic                    last_gnt, last_gnt_nxt;
`endif

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (REQ0_VLD && REQ1_VLD) begin
`ifdef TX_SCHED_ROUND_ROBIN_EN
            gnt0 = last_gnt;
            gnt1 = !last_gnt;
`else
            gnt0 = 1'b1;
`endif
        end else begin
            gnt0 = REQ0_VLD;
            gnt1 = REQ1_VLD;
        end
    end

    always_comb begin
        state_nxt         = state;
        cur_byte_nxt      = cur_byte;
        msb_byte_nxt      = msb_byte;
        msb_pend_nxt      = msb_pend;
        tx_p_data_nxt     = TX_P_DATA;
        tx_data_valid_nxt = 1'b0;
        req0_ack_nxt      = 1'b0;
        req1_ack_nxt      = 1'b0;
`ifdef TX_SCHED_ROUND_ROBIN_EN
        last_gnt_nxt      = last_gnt;
`endif
        case (state)
            IDLE: begin
                if (gnt0) begin
                    cur_byte_nxt = REQ0_DATA;
                    msb_pend_nxt = 1'b0;
                    req0_ack_nxt = 1'b1;
                    state_nxt    = LOAD;
`ifdef TX_SCHED_ROUND_ROBIN_EN
                    last_gnt_nxt = 1'b0;
`endif
                end else if (gnt1) begin
                    cur_byte_nxt = REQ1_DATA[DATA_WIDTH-1:0];
                    msb_byte_nxt = REQ1_DATA[2*DATA_WIDTH-1:DATA_WIDTH];
                    msb_pend_nxt = 1'b1;
                    req1_ack_nxt = 1'b1;
                    state_nxt    = LOAD;
`ifdef TX_SCHED_ROUND_ROBIN_EN
                    last_gnt_nxt = 1'b1;
`endif
                end
            end
            LOAD: begin
                tx_p_data_nxt     = cur_byte;
                tx_data_valid_nxt = 1'b1;
                state_nxt         = WAIT_HI;
            end
            WAIT_HI: begin
                if (TX_BUSY) begin
                    state_nxt = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (!TX_BUSY) begin
                    if (msb_pend) begin
                        cur_byte_nxt = msb_byte;
                        msb_pend_nxt = 1'b0;
                        state_nxt    = LOAD;
                    end else begin
                        state_nxt    = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        sched_busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state         <= IDLE;
            cur_byte      <= '0;
            msb_byte      <= '0;
            msb_pend      <= 1'b0;
            TX_P_DATA     <= '0;
            TX_DATA_VALID <= 1'b0;
            REQ0_ACK      <= 1'b0;
            REQ1_ACK      <= 1'b0;
            SCHED_BUSY    <= 1'b0;
`ifdef TX_SCHED_ROUND_ROBIN_EN
            last_gnt      <= 1'b1;
`endif
        end else begin
            state         <= state_nxt;
            cur_byte      <= cur_byte_nxt;
            msb_byte      <= msb_byte_nxt;
            msb_pend      <= msb_pend_nxt;
            TX_P_DATA     <= tx_p_data_nxt;
            TX_DATA_VALID <= tx_data_valid_nxt;
            REQ0_ACK      <= req0_ack_nxt;
            REQ1_ACK      <= req1_ack_nxt;
            SCHED_BUSY    <= sched_busy_nxt;
`ifdef TX_SCHED_ROUND_ROBIN_EN
            last_gnt      <= last_gnt_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: directed and random requests against a grant-order / byte-queue reference model.
module tb_uart_tx_sched;

    logic        CLK = 1'b0;
    logic        RST;
    logic        REQ0_VLD;
    logic [7:0]  REQ0_DATA;
    logic        REQ0_ACK;
    logic        REQ1_VLD;
    logic [15:0] REQ1_DATA;
    logic        REQ1_ACK;
    logic        TX_BUSY;
    logic [7:0]  TX_P_DATA;
    logic        TX_DATA_VALID;
    logic        SCHED_BUSY;

    uart_tx_sched #(.DATA_WIDTH(8)) dut (
        .CLK(CLK), .RST(RST),
        .REQ0_VLD(REQ0_VLD), .REQ0_DATA(REQ0_DATA), .REQ0_ACK(REQ0_ACK),
        .REQ1_VLD(REQ1_VLD), .REQ1_DATA(REQ1_DATA), .REQ1_ACK(REQ1_ACK),
        .TX_BUSY(TX_BUSY), .TX_P_DATA(TX_P_DATA), .TX_DATA_VALID(TX_DATA_VALID),
        .SCHED_BUSY(SCHED_BUSY)
    );

    always #5 CLK = ~CLK;

    int vectors = 0;
    int miscompares = 0;

    // Transmitter model: busy rises gap edges after seeing the strobe, stays high len cycles
    bit tx_model_en = 1'b1;
    int gap = 2;
    int len = 10;
    int tx_dly;
    int tx_cnt;
    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            TX_BUSY <= 1'b0;
            tx_dly  <= 0;
            tx_cnt  <= 0;
        end else if (TX_DATA_VALID && tx_model_en) begin
            tx_dly <= gap;
        end else if (tx_dly > 0) begin
            tx_dly <= tx_dly - 1;
            if (tx_dly == 1) begin
                TX_BUSY <= 1'b1;
                tx_cnt  <= len;
            end
        end else if (tx_cnt > 0) begin
            tx_cnt <= tx_cnt - 1;
            if (tx_cnt == 1) TX_BUSY <= 1'b0;
        end
    end

    // Observed event logs
    logic [7:0] strobe_q[$];
    int         strobe_falls[$];
    int         ack_q[$];
    int         busy_falls = 0;
    bit         busy_prev = 1'b0;
    always @(negedge CLK) begin
        if (RST) begin
            if (TX_DATA_VALID) begin
                strobe_q.push_back(TX_P_DATA);
                strobe_falls.push_back(busy_falls);
            end
            if (REQ0_ACK) ack_q.push_back(0);
            if (REQ1_ACK) ack_q.push_back(1);
            if (busy_prev && !TX_BUSY) busy_falls++;
        end
        busy_prev = TX_BUSY;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_tx_p_data"}, 32'(TX_P_DATA), 32'h0);
        chk({tag, "_tx_data_valid"}, 32'(TX_DATA_VALID), 32'h0);
        chk({tag, "_req0_ack"}, 32'(REQ0_ACK), 32'h0);
        chk({tag, "_req1_ack"}, 32'(REQ1_ACK), 32'h0);
        chk({tag, "_sched_busy"}, 32'(SCHED_BUSY), 32'h0);
    endtask

    // Reference: which requester was granted most recently (1 after reset)
    int m_last = 1;

    task automatic run_txn(input bit v0, input logic [7:0] d0, input bit v1, input logic [15:0] d1);
        int         order[$];
        logic [7:0] exp_b[$];
        int         sb, ab, fb, k;
        bit         done;
        if (v0 && v1) begin
`ifdef TX_SCHED_ROUND_ROBIN_EN
            if (m_last == 0) order = '{1, 0};
            else             order = '{0, 1};
`else
            order = '{0, 1};
`endif
        end else if (v0) order = '{0};
        else             order = '{1};
        m_last = order[order.size()-1];
        foreach (order[i]) begin
            if (order[i] == 0) exp_b.push_back(d0);
            else begin
                exp_b.push_back(d1[7:0]);
                exp_b.push_back(d1[15:8]);
            end
        end

        sb = strobe_q.size();
        ab = ack_q.size();
        fb = busy_falls;
        REQ0_VLD = v0; REQ0_DATA = d0;
        REQ1_VLD = v1; REQ1_DATA = d1;
        k = 0;
        done = 1'b0;
        while (!done && k < 400) begin
            @(negedge CLK);
            k++;
            if (k == 1) begin
                chk("ack0_latency", 32'(REQ0_ACK), 32'(order[0] == 0));
                chk("ack1_latency", 32'(REQ1_ACK), 32'(order[0] == 1));
            end
            if (k == 2) begin
                chk("strobe_latency", 32'(TX_DATA_VALID), 32'h1);
                chk("first_byte", 32'(TX_P_DATA), 32'(exp_b[0]));
            end
            if (REQ0_ACK) REQ0_VLD = 1'b0;
            if (REQ1_ACK) REQ1_VLD = 1'b0;
            if (k >= 2 && !REQ0_VLD && !REQ1_VLD && !SCHED_BUSY) done = 1'b1;
        end
        chk("txn_timeout", 32'(done), 32'h1);
        chk("ack_count", 32'(ack_q.size() - ab), 32'(order.size()));
        for (int i = 0; i < order.size(); i++)
            if (ab + i < ack_q.size()) chk("ack_order", 32'(ack_q[ab+i]), 32'(order[i]));
        chk("strobe_count", 32'(strobe_q.size() - sb), 32'(exp_b.size()));
        for (int i = 0; i < exp_b.size(); i++) begin
            if (sb + i < strobe_q.size()) begin
                chk("byte_order", 32'(strobe_q[sb+i]), 32'(exp_b[i]));
                chk("strobe_after_busy_fall", 32'(strobe_falls[sb+i] - fb), 32'(i));
            end
        end
    endtask

    initial begin
        int         sb, ab, k;
        logic [2:0] sel;
        RST = 1'b0;
        REQ0_VLD = 1'b0; REQ0_DATA = '0;
        REQ1_VLD = 1'b0; REQ1_DATA = '0;
        repeat (3) @(negedge CLK);
        chk_reset_outputs("reset");
        RST = 1'b1;
        @(negedge CLK);

        run_txn(1'b1, 8'hA5, 1'b0, 16'h0000);
        run_txn(1'b0, 8'h00, 1'b1, 16'h1234);
        run_txn(1'b1, 8'h11, 1'b1, 16'hBEEF);
        run_txn(1'b1, 8'h22, 1'b0, 16'h0000);
        run_txn(1'b1, 8'h33, 1'b1, 16'h4455);

        // Reset while the transmitter is busy with the LSB of 0xCAFE
        sb = strobe_q.size();
        REQ1_VLD = 1'b1; REQ1_DATA = 16'hCAFE;
        k = 0;
        while (!(strobe_q.size() > sb && TX_BUSY) && k < 100) begin
            @(negedge CLK);
            k++;
            if (REQ1_ACK) REQ1_VLD = 1'b0;
        end
        chk("cafe_lsb_timeout", 32'(k < 100), 32'h1);
        if (strobe_q.size() > sb) chk("cafe_lsb", 32'(strobe_q[sb]), 32'hFE);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        chk_reset_outputs("midframe_reset");
        @(negedge CLK);
        RST = 1'b1;
        m_last = 1;
        sb = strobe_q.size();
        ab = ack_q.size();
        repeat (30) @(negedge CLK);
        chk("no_msb_strobe", 32'(strobe_q.size() - sb), 32'h0);
        chk("no_ack_after_reset", 32'(ack_q.size() - ab), 32'h0);
        chk("idle_after_reset", 32'(SCHED_BUSY), 32'h0);
        run_txn(1'b1, 8'h5C, 1'b1, 16'h6789);

        for (int i = 0; i < 24; i++) begin
            gap = $urandom_range(1, 4);
            len = $urandom_range(1, 12);
            sel = 3'($urandom_range(1, 3));
            run_txn(sel[0], 8'($urandom), sel[1], 16'($urandom));
        end

        // Transmitter never goes busy: scheduler must park in WAIT_HI
        tx_model_en = 1'b0;
        sb = strobe_q.size();
        ab = ack_q.size();
        REQ0_VLD = 1'b1; REQ0_DATA = 8'h77;
        @(negedge CLK);
        chk("stuck_ack", 32'(REQ0_ACK), 32'h1);
        REQ0_VLD = 1'b0;
        REQ1_VLD = 1'b1; REQ1_DATA = 16'h9999;
        @(negedge CLK);
        chk("stuck_strobe", 32'(TX_P_DATA), 32'h77);
        repeat (20) @(negedge CLK);
        chk("stuck_sched_busy", 32'(SCHED_BUSY), 32'h1);
        chk("stuck_strobe_count", 32'(strobe_q.size() - sb), 32'h1);
        chk("stuck_ack_count", 32'(ack_q.size() - ab), 32'h1);
        REQ1_VLD = 1'b0;
        RST = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        tx_model_en = 1'b1;
        m_last = 1;
        gap = 2;
        len = 10;
        @(negedge CLK);
        run_txn(1'b1, 8'h11, 1'b1, 16'hBEEF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
